// File: rtl/vfd_scan_sequencer.sv
// vfd_scan_sequencer
//   Refresh sequencer for the MN15439A VFD. Each grid slot lasts PERIOD
//   clocks. At the start of a slot it raises BLK and LAT. LAT falls after
//   LAT_LEN cycles. BLK falls after BLK_LEN cycles, and XFER_EN opens the
//   Tri-SPI/GCP window at that point. The window closes on XFER_DONE or after
//   XFER_TMO cycles, and GN then advances. The sequencer pauses at a slot
//   start while the host holds HOST_CS_N low.
//
//   Optional feature macro: VFD_SCAN_FRAME_SYNC_EN
//     defined   - a host pause is honoured only at a frame boundary (GN==1)
//     undefined - a host pause is honoured at the next slot start
//
// Ports:
//   CLK          in   system clock (12 MHz)
//   RST_N        in   asynchronous active-low reset
//   HOST_CS_N    in   host SPI chip select (asynchronous, low = host owns GRAM)
//   XFER_DONE    in   one-cycle pulse from Tri-SPI when the transfer finishes
//   BLK          out  display blanking
//   LAT          out  serial latch
//   XFER_EN      out  enable for TSPI SCE and GCPCLK PCE
//   GN[5:0]      out  current grid number, 1..GRIDS
//   FRAME_START  out  one-cycle pulse at the slot start with GN==1
//   SCAN_ACTIVE  out  high while slots are being issued
//   XFER_ERR     out  sticky transfer-timeout flag
module vfd_scan_sequencer #(
    parameter int unsigned PERIOD   = 3846,
    parameter int unsigned GRIDS    = 52,
    parameter int unsigned LAT_LEN  = 3,
    parameter int unsigned BLK_LEN  = 117,
    parameter int unsigned XFER_TMO = 296
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HOST_CS_N,
    input  logic       XFER_DONE,
    output logic       BLK,
    output logic       LAT,
    output logic       XFER_EN,
    output logic [5:0] GN,
    output logic       FRAME_START,
    output logic       SCAN_ACTIVE,
    output logic       XFER_ERR
);

    localparam int unsigned CW = $clog2(PERIOD);
    localparam int unsigned TW = $clog2(XFER_TMO + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] LAT_END  = CW'(LAT_LEN);
    localparam logic [CW-1:0] BLK_END  = CW'(BLK_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(XFER_TMO - 1);
    localparam logic [5:0]    GN_LAST  = 6'(GRIDS);

    typedef enum logic [1:0] {IDLE, BLANK, XFER, HOLD} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmo_q;
    logic            cs_meta_q, cs_s_q;
    logic            blk_q, lat_q, xfer_q, frame_q, scan_q, err_q;
    logic [5:0]      gn_q, gn_next;
    logic            slot_go;

    // The slot counter runs freely in every state. Slot timing therefore
    // never drifts, whatever happens with pauses or timeouts.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The synchronizer resets to "host idle" so that the first slot after
    // reset can start at counter 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_meta_q <= 1'b1;
            cs_s_q    <= 1'b1;
        end else begin
            cs_meta_q <= HOST_CS_N;
            cs_s_q    <= cs_meta_q;
        end
    end

    assign gn_next = (gn_q == GN_LAST) ? 6'd1 : gn_q + 6'd1;

`ifdef VFD_SCAN_FRAME_SYNC_EN
    // Mid-frame, the host request is deferred until GN wraps back to 1.
    assign slot_go = cs_s_q || (gn_q != 6'd1);
`else
    assign slot_go = cs_s_q;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            blk_q   <= 1'b0;
            lat_q   <= 1'b0;
            xfer_q  <= 1'b0;
            frame_q <= 1'b0;
            scan_q  <= 1'b0;
            err_q   <= 1'b0;
            gn_q    <= 6'd1;
            tmo_q   <= '0;
        end else begin
            frame_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cnt_q == '0) begin
                        if (slot_go) begin
                            state_q <= BLANK;
                            blk_q   <= 1'b1;
                            lat_q   <= 1'b1;
                            scan_q  <= 1'b1;
                            frame_q <= (gn_q == 6'd1);
                        end else begin
                            scan_q  <= 1'b0;
                        end
                    end
                end
                BLANK: begin
                    if (cnt_q == LAT_END) begin
                        lat_q <= 1'b0;
                    end
                    if (cnt_q == BLK_END) begin
                        blk_q   <= 1'b0;
                        xfer_q  <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    // A done pulse on the final window cycle takes
                    // precedence over the timeout.
                    if (XFER_DONE || (tmo_q == TMO_LAST)) begin
                        xfer_q  <= 1'b0;
                        gn_q    <= gn_next;
                        state_q <= HOLD;
                        if (!XFER_DONE) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BLK         = blk_q;
    assign LAT         = lat_q;
    assign XFER_EN     = xfer_q;
    assign GN          = gn_q;
    assign FRAME_START = frame_q;
    assign SCAN_ACTIVE = scan_q;
    assign XFER_ERR    = err_q;

endmodule

// File: tb/tb_vfd_scan_sequencer.sv
// tb_vfd_scan_sequencer
//   Scoreboard bench for vfd_scan_sequencer. The stimulus process pushes one
//   expected record per slot it intends the DUT to issue. The monitor pops a
//   record on every BLK rising edge and checks the slot timing, GN and the
//   flags. The slot period is shortened so that several full frames fit in a
//   short run.
module tb_vfd_scan_sequencer;

    localparam int unsigned P    = 450;
    localparam int unsigned GR   = 52;
    localparam int unsigned LATL = 3;
    localparam int unsigned BLKL = 117;
    localparam int unsigned TMO  = 296;
    localparam int unsigned DONE_DLY = 288;

    logic       CLK, RST_N, HOST_CS_N, XFER_DONE;
    logic       BLK, LAT, XFER_EN, FRAME_START, SCAN_ACTIVE, XFER_ERR;
    logic [5:0] GN;

    vfd_scan_sequencer #(
        .PERIOD   (P),
        .GRIDS    (GR),
        .LAT_LEN  (LATL),
        .BLK_LEN  (BLKL),
        .XFER_TMO (TMO)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .HOST_CS_N   (HOST_CS_N),
        .XFER_DONE   (XFER_DONE),
        .BLK         (BLK),
        .LAT         (LAT),
        .XFER_EN     (XFER_EN),
        .GN          (GN),
        .FRAME_START (FRAME_START),
        .SCAN_ACTIVE (SCAN_ACTIVE),
        .XFER_ERR    (XFER_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned gn;
        int unsigned fs;
        int unsigned xlen;
        int unsigned gn_after;
        int unsigned err;
    } slot_t;

    slot_t       exp_q[$];
    int unsigned fs_t[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned slots_done = 0;
    int unsigned slots_started = 0;
    int unsigned ncyc = 0;
    int unsigned tb_phase = 0;
    logic        done_mode = 1'b1;
    logic        mon_en = 1'b1;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_slot(input int unsigned gn, input int unsigned xlen, input int unsigned err);
        slot_t s;
        s.gn       = gn;
        s.fs       = (gn == 1) ? 1 : 0;
        s.xlen     = xlen;
        s.gn_after = (gn == GR) ? 1 : gn + 1;
        s.err      = err;
        exp_q.push_back(s);
    endtask

    task automatic wait_slots(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (slots_done < n && k < budget) begin
            @(posedge CLK);
            k++;
        end
        check("slots_done", slots_done, n);
    endtask

    task automatic wait_started(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (slots_started < n && k < budget) begin
            @(posedge CLK);
            k++;
        end
        check("slots_started", slots_started, n);
    endtask

    task automatic wait_xen(input int unsigned budget);
        int unsigned k = 0;
        while (!XFER_EN && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check("xen_seen", XFER_EN, 1);
    endtask

    // Reference slot phase: the counter value the DUT holds after each edge.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tb_phase <= 0;
        else        tb_phase <= (tb_phase == P - 1) ? 0 : tb_phase + 1;
    end

    always @(posedge CLK) ncyc <= ncyc + 1;

    // Tri-SPI stand-in: pulses XFER_DONE once XFER_EN has been seen high for
    // DONE_DLY cycles. It stays silent in timeout mode.
    initial begin : responder
        int unsigned rcnt = 0;
        XFER_DONE = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RST_N || !XFER_EN) begin
                rcnt      = 0;
                XFER_DONE = 1'b0;
            end else begin
                rcnt++;
                XFER_DONE = (done_mode && rcnt == DONE_DLY) ? 1'b1 : 1'b0;
            end
        end
    end

    initial begin : monitor
        slot_t       cur;
        int unsigned mst = 0, lat_n = 0, blk_n = 0, xen_n = 0;
        logic        blk_p = 1'b0, xen_p = 1'b0;
        cur = '{0, 0, 0, 0, 0};
        forever begin
            @(negedge CLK);
            if (!RST_N || !mon_en) begin
                mst = 0;
            end else begin
                if (FRAME_START) fs_t.push_back(ncyc);
                if (mst == 0) begin
                    if (BLK && !blk_p) begin
                        check("slot_expected", (exp_q.size() != 0) ? 1 : 0, 1);
                        if (exp_q.size() != 0) begin
                            cur = exp_q.pop_front();
                            slots_started++;
                            check("start_phase", tb_phase, 1);
                            check("start_gn", GN, cur.gn);
                            check("start_fs", FRAME_START, cur.fs);
                            check("start_lat", LAT, 1);
                            check("start_scan", SCAN_ACTIVE, 1);
                            lat_n = 1;
                            blk_n = 1;
                            xen_n = 0;
                            mst   = 1;
                        end
                    end
                end else begin
                    if (LAT) lat_n++;
                    if (BLK) blk_n++;
                    if (XFER_EN) begin
                        if (!xen_p) begin
                            check("blk_off_at_xen", BLK, 0);
                            check("gn_in_xfer", GN, cur.gn);
                        end
                        xen_n++;
                    end else if (xen_p) begin
                        check("lat_len", lat_n, LATL);
                        check("blk_len", blk_n, BLKL);
                        check("xen_len", xen_n, cur.xlen);
                        check("gn_after", GN, cur.gn_after);
                        check("xfer_err", XFER_ERR, cur.err);
                        slots_done++;
                        mst = 0;
                    end
                end
            end
            blk_p = BLK;
            xen_p = XFER_EN;
        end
    end

    initial begin : stim
        int unsigned total;
        RST_N     = 1'b0;
        HOST_CS_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_blk", BLK, 0);
        check("rst_lat", LAT, 0);
        check("rst_xen", XFER_EN, 0);
        check("rst_gn", GN, 1);
        check("rst_fs", FRAME_START, 0);
        check("rst_scan", SCAN_ACTIVE, 0);
        check("rst_err", XFER_ERR, 0);

        // One full frame plus the wrap back to GN=1.
        for (int g = 1; g <= int'(GR); g++) push_slot(g, DONE_DLY, 0);
        push_slot(1, DONE_DLY, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_slots(GR + 1, (GR + 3) * P);
        check("fs_count", fs_t.size(), 2);
        if (fs_t.size() >= 2) check("fs_spacing", fs_t[1] - fs_t[0], GR * P);

        // Transfer timeout: GN still advances and XFER_ERR becomes sticky.
        done_mode = 1'b0;
        push_slot(2, TMO, 1);
        wait_slots(GR + 2, 3 * P);
        done_mode = 1'b1;

        for (int g = 3; g <= 10; g++) push_slot(g, DONE_DLY, 1);
        wait_started(GR + 10, 10 * P);
        wait_xen(P);
        repeat (20) @(posedge CLK);
        #1 HOST_CS_N = 1'b0;
`ifdef VFD_SCAN_FRAME_SYNC_EN
        for (int g = 11; g <= int'(GR); g++) push_slot(g, DONE_DLY, 1);
        total = GR + GR;
        wait_slots(total, (GR + 2) * P);
        repeat (3 * P) @(posedge CLK);
        #1;
        check("pause_scan", SCAN_ACTIVE, 0);
        check("pause_blk", BLK, 0);
        check("pause_lat", LAT, 0);
        check("pause_xen", XFER_EN, 0);
        check("pause_gn", GN, 1);
        HOST_CS_N = 1'b1;
        push_slot(1, DONE_DLY, 1);
        push_slot(2, DONE_DLY, 1);
        total = total + 2;
`else
        total = GR + 10;
        wait_slots(total, 2 * P);
        repeat (3 * P) @(posedge CLK);
        #1;
        check("pause_scan", SCAN_ACTIVE, 0);
        check("pause_blk", BLK, 0);
        check("pause_lat", LAT, 0);
        check("pause_xen", XFER_EN, 0);
        check("pause_gn", GN, 11);
        HOST_CS_N = 1'b1;
        push_slot(11, DONE_DLY, 1);
        push_slot(12, DONE_DLY, 1);
        total = total + 2;
`endif
        wait_slots(total, 4 * P);

        // Reset in the middle of a transfer.
        mon_en = 1'b0;
        wait_xen(2 * P);
        repeat (10) @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("arst_xen", XFER_EN, 0);
        check("arst_blk", BLK, 0);
        check("arst_lat", LAT, 0);
        check("arst_gn", GN, 1);
        check("arst_err", XFER_ERR, 0);
        check("arst_scan", SCAN_ACTIVE, 0);
        @(negedge CLK);
        RST_N  = 1'b1;
        mon_en = 1'b1;
        push_slot(1, DONE_DLY, 0);
        wait_slots(total + 1, 2 * P);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vfd_scan_sequencer.md
Name: vfd_scan_sequencer

Overview:
Sequences the MN15439A refresh. Once per grid slot it pulses blank and latch, opens the Tri-SPI and GCP enable window, waits for the transfer-done handshake, then advances the grid number. It also pauses scanning while the host owns the graphic RAM through the slave-SPI chip select. It replaces the ad-hoc timing counters in top and drives TSPI SCE, GCPCLK PCE, BLK, LAT and GN.

Parameters:
PERIOD, 3846, CLK cycles per grid slot (12 MHz / 3120 Hz).
GRIDS, 52, number of grids; GN runs 1..GRIDS.
LAT_LEN, 3, LAT high time in cycles.
BLK_LEN, 117, BLK high time in cycles, measured from slot start.
XFER_TMO, 296, maximum XFER_EN cycles before timeout.
Constraints: LAT_LEN < BLK_LEN; BLK_LEN + XFER_TMO + 4 < PERIOD.

Ports:
CLK  in  1  system clock, 12 MHz
RST_N  in  1  asynchronous active-low reset
HOST_CS_N  in  1  host SPI chip select, asynchronous; low = host writing GRAM
XFER_DONE  in  1  one-cycle pulse from Tri-SPI after 288 bits are sent
BLK  out  1  display blanking
LAT  out  1  serial latch
XFER_EN  out  1  enable for TSPI SCE and GCPCLK PCE
GN  out  6  current grid number, 1..GRIDS
FRAME_START  out  1  one-cycle pulse at the slot start where GN==1
SCAN_ACTIVE  out  1  high while slots are being issued
XFER_ERR  out  1  sticky transfer-timeout flag

Behaviour:
- Reset (RST_N low, asynchronous) forces all outputs low, except GN=1. Slot counter = 0; state IDLE. Reset mid-slot abandons the slot immediately; BLK, LAT and XFER_EN drop in the same instant.
- HOST_CS_N passes through a 2-flop synchronizer into cs_s. Two cycles of latency are acceptable.
- The slot counter runs 0..PERIOD-1 and wraps; it is free-running in every state, including IDLE.
- States: IDLE, BLANK, XFER, HOLD.
- IDLE: at counter==0 with cs_s=1, enter BLANK, assert BLK=1 and LAT=1, and set SCAN_ACTIVE=1. FRAME_START=1 for that cycle if GN==1. With cs_s=0, stay in IDLE and hold SCAN_ACTIVE=0.
- BLANK: LAT falls at counter==LAT_LEN. At counter==BLK_LEN, BLK falls, XFER_EN rises and the state becomes XFER.
- XFER: XFER_EN stays high until XFER_DONE is sampled high. XFER_EN drops on the cycle after that sample, and the state becomes HOLD.
  - If XFER_TMO cycles elapse without XFER_DONE, XFER_EN drops, XFER_ERR sets and the state becomes HOLD.
  - XFER_DONE outside XFER is ignored.
- HOLD: on entry, GN advances (GN==GRIDS wraps to 1). This happens on both the done path and the timeout path. The state waits for counter==PERIOD-1, then goes to IDLE. IDLE starts the next slot on the counter==0 cycle that follows.
- GN changes only on HOLD entry, never during BLANK or XFER, so TSPI sees a stable GN.
- XFER_ERR clears only on reset.
- Host pause, decided at the slot start in IDLE: a slot already in progress always completes, and XFER_EN is never cut short by HOST_CS_N.
- While paused, GN holds its value. Scanning resumes at the first counter==0 with cs_s=1.

Optional Feature:
Macro: VFD_SCAN_FRAME_SYNC_EN.
- Defined: a pause is honoured only at a frame boundary, i.e. in IDLE with GN==1. A HOST_CS_N low mid-frame lets the remaining grids through GRIDS complete first. Resume therefore always starts at GN=1 with FRAME_START.
- Undefined: a pause takes effect at the next slot start regardless of GN, and resume continues from the held GN.

Test Plan:
- Release reset with HOST_CS_N=1 and XFER_DONE returned 288 cycles after XFER_EN rises → at counter 0: BLK=1, LAT=1, FRAME_START=1, GN=1. LAT falls at cycle 3, BLK falls and XFER_EN rises at cycle 117, XFER_EN falls at cycle 406, GN=2.
- Run 52 slots → GN sequence 1..52 then 1. FRAME_START pulses exactly once per 52×3846 cycles.
- Hold XFER_DONE low → XFER_EN falls after 296 cycles, XFER_ERR=1 and stays 1, GN still advances.
- Macro undefined: drive HOST_CS_N low during the GN=10 transfer → that slot completes and GN=11. No BLK, LAT or XFER_EN while low; SCAN_ACTIVE=0. Raising HOST_CS_N resumes at GN=11.
- Macro defined, same stimulus → slots continue through GN=52, then pause. Resume starts at GN=1 with FRAME_START.
- Assert RST_N low during XFER → XFER_EN, BLK and LAT go low asynchronously and GN=1. After release, the first slot starts at counter 0.
